// File: rtl/ext_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_pkg : shared extension opcodes for the immediate extender         |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
package ext_pkg;
  localparam int EXT_ZERO   = 0;
  localparam int EXT_SIGN   = 1;
  localparam int EXT_LUI    = 2;
  localparam int EXT_BRANCH = 3;
  localparam int EXT_OP_MAX = 3;
endpackage
`default_nettype wire

// File: rtl/ext_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_core : combinational immediate extender (zero/sign/lui/branch)    |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
module ext_core
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);
  logic signed [IMM_W-1:0]  imm_s;
  logic signed [DATA_W-1:0] sext;
  logic [DATA_W-1:0]        zext;

  always_comb begin
    imm_s = $signed(imm);
    sext  = DATA_W'(imm_s);
    zext  = DATA_W'(imm);
    case (int'(op))
      EXT_ZERO:   result = zext;
      EXT_SIGN:   result = $unsigned(sext);
      // Shift by zero is legal, so IMM_W == DATA_W needs no special case.
      EXT_LUI:    result = zext << (DATA_W - IMM_W);
      EXT_BRANCH: result = $unsigned(sext) << 2;
      default:    result = '0;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/ext_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ext_pipe : pipelined immediate extender with 2-entry skid buffer      |
// | optional macro EXT_ILLEGAL_TRAP_EN adds sticky out_err. rev 1.0       |
// +----------------------------------------------------------------------+
module ext_pipe
  import ext_pkg::*;
#(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
`ifdef EXT_ILLEGAL_TRAP_EN
  output logic              out_err,
`endif
  output logic [DATA_W-1:0] out_imm
);
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_imm_q, out_imm_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_imm_q, skid_imm_d;
  logic [DATA_W-1:0] ext_res;
  logic              accept;
  logic              drain;

  ext_core #(.IMM_W(IMM_W), .DATA_W(DATA_W), .OP_W(OP_W)) u_core (
    .imm    (in_imm),
    .op     (in_op),
    .result (ext_res)
  );

  assign in_ready  = ~skid_valid_q;
  assign out_valid = out_valid_q;
  assign out_imm   = out_imm_q;
  assign accept    = in_valid & in_ready & ~flush;
  assign drain     = out_valid_q & out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (drain && skid_valid_q) begin
      // Skid full means in_ready was low, so nothing new arrives this edge.
      out_imm_d    = skid_imm_q;
      skid_valid_d = 1'b0;
    end else if (drain || !out_valid_q) begin
      out_valid_d = accept;
      if (accept) out_imm_d = ext_res;
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = ext_res;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
    end
  end

`ifdef EXT_ILLEGAL_TRAP_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (accept & (int'(in_op) > EXT_OP_MAX));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign out_err = err_q;
`endif
endmodule
`default_nettype wire
